// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite types used by the command master.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    READ  = 2'b10
  } dir_e;

  localparam int unsigned CntWidth = 4;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Single-beat command stream to AXI-Lite master with an in-order merged
// response stream. The direction lock (IDLE/WRITE/READ) keeps B and R replies
// from ever interleaving, so responses can be passed straight through.
// Optional: define AXI_LITE_CMD_MASTER_ERR_COUNT_EN to add a saturating
// 16-bit count of non-OKAY responses on port err_count.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32
) (
  input  logic                   a_clk,
  input  logic                   a_reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [AddrWidth-1:0]   cmd_addr,
  input  logic [DataWidth-1:0]   cmd_wdata,
  input  logic [DataWidth/8-1:0] cmd_wstrb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_write,
  output logic [DataWidth-1:0]   rsp_rdata,
  output logic [1:0]             rsp_resp,
  output logic                   aw_valid,
  input  logic                   aw_ready,
  output logic [AddrWidth-1:0]   aw_addr,
  output logic                   w_valid,
  input  logic                   w_ready,
  output logic [DataWidth-1:0]   w_data,
  output logic [DataWidth/8-1:0] w_strb,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [1:0]             b_resp,
  output logic                   ar_valid,
  input  logic                   ar_ready,
  output logic [AddrWidth-1:0]   ar_addr,
  input  logic                   r_valid,
  output logic                   r_ready,
  input  logic [DataWidth-1:0]   r_data,
  input  logic [1:0]             r_resp
`ifdef AXI_LITE_CMD_MASTER_ERR_COUNT_EN
  ,
  output logic [15:0]            err_count
`endif
);

  logic                   awValid_q;
  logic                   wValid_q;
  logic                   arValid_q;
  logic [AddrWidth-1:0]   awAddr_q;
  logic [AddrWidth-1:0]   arAddr_q;
  logic [DataWidth-1:0]   wData_q;
  logic [DataWidth/8-1:0] wStrb_q;
  logic [CntWidth-1:0]    outstanding_q;
  logic [CntWidth-1:0]    outstanding_d;
  dir_e                   dir_q;
  dir_e                   dir_d;

  logic writeSlotFree;
  logic readSlotFree;
  logic drained;
  logic creditOk;
  logic dirOk;
  logic cmdFire;
  logic rspFire;

  assign rsp_valid = b_valid | r_valid;
  assign b_ready   = rsp_ready;
  assign r_ready   = rsp_ready;
  assign rsp_write = b_valid;
  assign rsp_resp  = b_valid ? b_resp : r_resp;
  assign rsp_rdata = r_valid ? r_data : '0;
  assign rspFire   = rsp_valid & rsp_ready;

  assign aw_valid = awValid_q;
  assign aw_addr  = awAddr_q;
  assign w_valid  = wValid_q;
  assign w_data   = wData_q;
  assign w_strb   = wStrb_q;
  assign ar_valid = arValid_q;
  assign ar_addr  = arAddr_q;

  // Acceptance decision plus next direction and outstanding count.
  always_comb begin
    dir_d         = dir_q;
    outstanding_d = outstanding_q;
    writeSlotFree = (!awValid_q || aw_ready) && (!wValid_q || w_ready);
    readSlotFree  = !arValid_q || ar_ready;
    drained       = (outstanding_q == '0) && !awValid_q && !wValid_q && !arValid_q;
    creditOk      = (outstanding_q < CntWidth'(MaxOutstanding)) || rspFire;
    dirOk         = 1'b0;
    unique case (dir_q)
      IDLE:    dirOk = 1'b1;
      WRITE:   dirOk = cmd_write || drained;
      READ:    dirOk = !cmd_write || drained;
      default: dirOk = 1'b0;
    endcase
    cmd_ready = a_reset_n && (cmd_write ? writeSlotFree : readSlotFree) && creditOk && dirOk;
    cmdFire   = cmd_valid && cmd_ready;
    if (cmdFire && !rspFire) begin
      outstanding_d = outstanding_q + CntWidth'(1);
    end else if (!cmdFire && rspFire && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - CntWidth'(1);
    end
    if (cmdFire) begin
      dir_d = cmd_write ? WRITE : READ;
    end else if (outstanding_d == '0) begin
      dir_d = IDLE;
    end
  end

  // Direction and outstanding-count state registers.
  always_ff @(posedge a_clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      dir_q         <= IDLE;
      outstanding_q <= '0;
    end else begin
      dir_q         <= dir_d;
      outstanding_q <= outstanding_d;
    end
  end

  // Write issue registers: AW and W load together, then retire independently.
  always_ff @(posedge a_clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      awValid_q <= 1'b0;
      awAddr_q  <= '0;
      wValid_q  <= 1'b0;
      wData_q   <= '0;
      wStrb_q   <= '0;
    end else if (cmdFire && cmd_write) begin
      awValid_q <= 1'b1;
      awAddr_q  <= cmd_addr;
      wValid_q  <= 1'b1;
      wData_q   <= cmd_wdata;
      wStrb_q   <= cmd_wstrb;
    end else begin
      if (aw_ready) awValid_q <= 1'b0;
      if (w_ready)  wValid_q  <= 1'b0;
    end
  end

  // Read issue register: AR held until its own handshake.
  always_ff @(posedge a_clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      arValid_q <= 1'b0;
      arAddr_q  <= '0;
    end else if (cmdFire && !cmd_write) begin
      arValid_q <= 1'b1;
      arAddr_q  <= cmd_addr;
    end else if (ar_ready) begin
      arValid_q <= 1'b0;
    end
  end

`ifdef AXI_LITE_CMD_MASTER_ERR_COUNT_EN
  logic [15:0] errCount_q;

  // Count non-OKAY response handshakes, saturating at all-ones.
  always_ff @(posedge a_clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      errCount_q <= '0;
    end else if (rspFire && (rsp_resp != OKAY) && (errCount_q != 16'hFFFF)) begin
      errCount_q <= errCount_q + 16'd1;
    end
  end

  assign err_count = errCount_q;
`endif

  noDualReply: assert property (@(posedge a_clk) disable iff (!a_reset_n) !(b_valid && r_valid));

endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
- Upstream AXI-Lite master that feeds the AXI-Lite register block.
- Converts a simple single-beat command stream (read/write, addr, data, strobe) into AW/W/AR transactions.
- Merges B/R replies into one in-order response stream.
- Sustains 1 command/cycle, so the downstream 2-cycle-latency register file runs at full throughput.

Parameters:
- MaxOutstanding, 4: max accepted commands without a returned response (1..15).
- AddrWidth, 32: address width.
- DataWidth, 32: data width; strobe width is DataWidth/8.

Ports:
- a_clk  in  1  clock
- a_reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  AddrWidth  byte address
- cmd_wdata  in  DataWidth  write data
- cmd_wstrb  in  DataWidth/8  byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DataWidth  read data (0 for writes)
- rsp_resp  out  2  AXI resp code
- aw_valid/aw_ready/aw_addr  out/in/out  1/1/AddrWidth  write address channel
- w_valid/w_ready/w_data/w_strb  out/in/out/out  1/1/DataWidth/DataWidth/8  write data channel
- b_valid/b_ready/b_resp  in/out/in  1/1/2  write response channel
- ar_valid/ar_ready/ar_addr  out/in/out  1/1/AddrWidth  read address channel
- r_valid/r_ready/r_data/r_resp  in/out/in/in  1/1/DataWidth/2  read data channel

Behaviour:
- Reset:
  - Clock a_clk; reset a_reset_n is asynchronous, active-low.
  - During reset: aw_valid=w_valid=ar_valid=0, cmd_ready=0, rsp_valid=0.
  - State on release: addr/data regs 0, outstanding=0, dir=IDLE.
  - Reset mid-transaction drops everything; no response is generated for lost commands.
- Issue registers:
  - aw_valid, w_valid, ar_valid and their payloads are registered.
  - Each is set the cycle after command acceptance and held stable until its own handshake.
  - AW and W complete independently, in either order.
  - A valid never depends on its ready.
- Slot free conditions:
  - Write slot free = (!aw_valid|aw_ready) & (!w_valid|w_ready).
  - Read slot free = (!ar_valid|ar_ready).
- cmd_ready (combinational):
  - Requires the slot for cmd_write to be free.
  - Requires outstanding < MaxOutstanding, or a response handshake this cycle.
  - Requires the direction check to pass.
- Direction FSM (IDLE, WRITE, READ) keeps responses in order:
  - IDLE accepts either command type and moves to its type.
  - WRITE/READ accept only the same type.
  - An opposite-type command stalls (cmd_ready=0) until outstanding==0 and no AW/W/AR pending, then the FSM switches.
  - Return to IDLE when outstanding reaches 0.
- Outstanding counter:
  - +1 on command accept; -1 on rsp handshake; both in one cycle leaves it unchanged.
  - Never exceeds MaxOutstanding and never underflows.
- Response path (combinational pass-through, zero added latency):
  - rsp_valid = b_valid|r_valid.
  - b_ready = r_ready = rsp_ready.
  - rsp_write = b_valid.
  - rsp_resp = b_valid ? b_resp : r_resp.
  - rsp_rdata = r_valid ? r_data : 0.
  - The direction lock guarantees b_valid and r_valid are never both high; that condition is an assertion.
- Latency and throughput:
  - Command accept at cycle t drives AXI valid at t+1.
  - With an always-ready slave and rsp_ready=1, back-to-back commands are accepted every cycle.

Optional Feature:
- Macro: AXI_LITE_CMD_MASTER_ERR_COUNT_EN.
- When defined:
  - Adds output err_count (16 bit).
  - Increments on every rsp handshake with rsp_resp != OKAY, saturating at 16'hFFFF.
  - Reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package axi_lite_pkg:
  - resp_e: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - dir_e: IDLE, WRITE, READ.
- Single module. No sub-module is needed; the three issue registers are uniform enough to write inline.

Test Plan (DUT driving the AXI-Lite register block, BaseAddr=32'h3000_1000, always ready):
- 64 back-to-back writes to BaseAddr+4*i with random data, rsp_ready=1 -> 64 rsp with rsp_write=1, resp=2'b00, last response 66 cycles after first accept.
- 64 reads following those writes -> rsp_rdata matches each written word in order; 66 cycles total.
- Alternating W/R/W/R to the same address 32'h3000_1000 -> each read sees the preceding write; cmd_ready low while the direction drains.
- rsp_ready held low for 10 cycles after 6 writes -> cmd_ready drops after 4 accepts (MaxOutstanding); resumes exactly 1/cycle after release; no response lost or duplicated.
- Write to 32'h3000_1100 and read of 32'h2000_0000 -> rsp_resp=2'b11; with the macro defined, err_count=2.
- Assert a_reset_n low with 3 writes outstanding -> all valids 0 asynchronously, outstanding=0; a subsequent read to BaseAddr returns 0.
